// File: rtl/vram_rect_fill_if.sv
// Bundle of the rectangle fill engine's command port and its VRAM arbiter port.
//   master : the side that issues commands and models the arbiter/VRAM
//   slave  : the fill engine itself
// Optional feature macro: VRAM_FILL_XOR_EN adds the cmd_xor command field.
interface vram_rect_fill_if #(
  parameter int ROW_W  = 640,
  parameter int ADDR_W = 9,
  parameter int X_W    = 10
);

  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [X_W-1:0]    cmd_x0;
  logic [X_W-1:0]    cmd_x1;
  logic [ADDR_W-1:0] cmd_y0;
  logic [ADDR_W-1:0] cmd_y1;
  logic              cmd_color;
`ifdef VRAM_FILL_XOR_EN
  logic              cmd_xor;
`endif

  // Arbiter / VRAM channel
  logic              grant;
  logic [ADDR_W-1:0] vram_addr;
  logic [ROW_W-1:0]  write_vram;
  logic              write_active;
  logic [ROW_W-1:0]  read_vram;

  // Status
  logic              busy;
  logic              done;

`ifdef VRAM_FILL_XOR_EN
  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_xor,
    output grant, read_vram,
    input  cmd_ready, vram_addr, write_vram, write_active, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_xor,
    input  grant, read_vram,
    output cmd_ready, vram_addr, write_vram, write_active, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output grant, read_vram,
    input  cmd_ready, vram_addr, write_vram, write_active, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  grant, read_vram,
    output cmd_ready, vram_addr, write_vram, write_active, busy, done
  );
`endif

endinterface

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: one writer client of the 8-port round-robin VRAM
// arbiter. Takes one rectangle command at a time and read-modify-writes every
// 1 bpp VRAM row it covers, using only the arbiter slots granted to it.
// Each row costs two grants: one read, one write of the merged row.
// Optional feature macro: VRAM_FILL_XOR_EN adds an XOR (invert) fill mode
// selected per command by cmd_xor.
module vram_rect_fill #(
  parameter int ROW_W  = 640,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 9,
  parameter int X_W    = 10
) (
  input logic           clk,
  input logic           rst,
  vram_rect_fill_if.slave bus
);

  localparam logic [X_W-1:0]    X_MAX = X_W'(ROW_W - 1);
  localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    WR_REQ,
    FINISH
  } state_t;

  state_t            state;

  // Registered command fields (x1/y1 held already clamped)
  logic [X_W-1:0]    x0_q;
  logic [X_W-1:0]    x1_q;
  logic [ADDR_W-1:0] y1_q;
  logic              color_q;
`ifdef VRAM_FILL_XOR_EN
  logic              xor_q;
`endif

  // Combinational helpers
  logic              accept;
  logic [X_W-1:0]    x1_clamp;
  logic [ADDR_W-1:0] y1_clamp;
  logic              cmd_empty;
  logic [ROW_W-1:0]  mask;
  logic [ROW_W-1:0]  merged;

  // Clamp the incoming rectangle to the visible area and classify it as empty.
  // Any y0 beyond the last row ends up empty here, so the row counter can
  // never step past ROWS-1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    accept    = 1'b0;
    x1_clamp  = bus.cmd_x1;
    y1_clamp  = bus.cmd_y1;
    cmd_empty = 1'b0;

    accept = bus.cmd_valid && bus.cmd_ready;
    if (bus.cmd_x1 > X_MAX) begin
      x1_clamp = X_MAX;
    end
    if (bus.cmd_y1 > Y_MAX) begin
      y1_clamp = Y_MAX;
    end
    cmd_empty = (bus.cmd_x0 > x1_clamp) || (bus.cmd_y0 > y1_clamp);
  end

  // Column mask from the registered span, and the merged row it produces.
  always_comb begin
    mask   = '0;
    merged = '0;

    for (int i = 0; i < ROW_W; i++) begin
      mask[i] = (x0_q <= X_W'(i)) && (X_W'(i) <= x1_q);
    end

`ifdef VRAM_FILL_XOR_EN
    if (xor_q) begin
      merged = bus.read_vram ^ mask;
    end else begin
      merged = (bus.read_vram & ~mask) | (color_q ? mask : '0);
    end
`else
    merged = (bus.read_vram & ~mask) | (color_q ? mask : '0);
`endif
  end

  // Control FSM with all outputs registered. vram_addr doubles as the row
  // counter, so the address the arbiter sees is always the row in progress.
  // write_vram doubles as the row buffer between the read and write grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state            <= IDLE;
      bus.cmd_ready    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.write_active <= 1'b0;
      bus.vram_addr    <= '0;
      bus.write_vram   <= '0;
      x0_q             <= '0;
      x1_q             <= '0;
      y1_q             <= '0;
      color_q          <= 1'b0;
`ifdef VRAM_FILL_XOR_EN
      xor_q            <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse, raised only on entry to FINISH
      bus.done <= 1'b0;

      case (state)
        IDLE: begin
          bus.cmd_ready    <= 1'b1;
          bus.write_active <= 1'b0;
          if (accept) begin
            x0_q          <= bus.cmd_x0;
            x1_q          <= x1_clamp;
            y1_q          <= y1_clamp;
            color_q       <= bus.cmd_color;
`ifdef VRAM_FILL_XOR_EN
            xor_q         <= bus.cmd_xor;
`endif
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (cmd_empty) begin
              // Nothing to draw: skip straight to completion, no VRAM access
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.vram_addr <= bus.cmd_y0;
              state         <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          // Read request rides on the address with write_active low
          if (bus.grant) begin
            state <= RD_CAP;
          end
        end

        RD_CAP: begin
          // Read data is valid this cycle; merge and present it for writing
          bus.write_vram   <= merged;
          bus.write_active <= 1'b1;
          state            <= WR_REQ;
        end

        WR_REQ: begin
          if (bus.grant) begin
            bus.write_active <= 1'b0;
            if (bus.vram_addr == y1_q) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.vram_addr <= bus.vram_addr + ADDR_W'(1);
              state         <= RD_REQ;
            end
          end
        end

        FINISH: begin
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end

        default: begin
          bus.write_active <= 1'b0;
          bus.busy         <= 1'b0;
          bus.cmd_ready    <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Testbench for vram_rect_fill: arbiter model granting every 8th cycle, a
// 480x640 RAM with 1-cycle read latency, and a scoreboard of expected row
// writes pushed at command issue and popped as the engine writes.
// Define VRAM_FILL_XOR_EN to also exercise the XOR fill mode.
`timescale 1ns/1ps
module tb_vram_rect_fill;

  localparam int ROW_W  = 640;
  localparam int ROWS   = 480;
  localparam int ADDR_W = 9;
  localparam int X_W    = 10;

  typedef logic [ROW_W-1:0] row_t;
  typedef struct {
    int   addr;
    row_t data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vram_rect_fill_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .X_W(X_W)) bus ();

  vram_rect_fill #(.ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .X_W(X_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  row_t    mem     [ROWS];
  row_t    ref_mem [ROWS];
  wr_exp_t exp_q   [$];

  int n_checks = 0;
  int n_fail   = 0;
  int writes   = 0;
  int bad_addr = 0;
  int done_cnt = 0;
  int wa_cnt   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input row_t obs, input row_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arbiter + RAM model: samples pre-edge DUT outputs on each rising edge,
  // performs the granted access, then updates grant/read data 1 ns later.
  initial begin : arb_model
    int      a;
    bit      rd_hit;
    int      rd_addr;
    wr_exp_t e;
    bus.grant     = 1'b0;
    bus.read_vram = '0;
    rd_addr       = 0;
    forever begin
      @(posedge clk);
      cyc++;
      rd_hit = 1'b0;
      if (bus.grant === 1'b1) begin
        a = int'(bus.vram_addr);
        if (a >= ROWS) begin
          bad_addr++;
        end else if (bus.write_active === 1'b1) begin
          writes++;
          mem[a] = bus.write_vram;
          check("wr_expected", row_t'(exp_q.size() != 0), row_t'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("wr_addr_%0d", e.addr), row_t'(a), row_t'(e.addr));
            check($sformatf("wr_data_%0d", e.addr), bus.write_vram, e.data);
            ref_mem[e.addr] = e.data;
          end
        end else begin
          rd_hit  = 1'b1;
          rd_addr = a;
        end
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.write_active === 1'b1) wa_cnt++;
      #1;
      if (rd_hit) bus.read_vram = mem[rd_addr];
      bus.grant = ((cyc % 8) == 7);
    end
  end

  // Issue one command (call at a falling edge); pushes the expected writes.
  task automatic issue_cmd(input int x0, input int x1, input int y0, input int y1,
                           input bit c, input bit xr);
    int      k;
    int      x1c;
    int      y1c;
    row_t    m;
    wr_exp_t e;
    k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_before_issue", row_t'(bus.cmd_ready), row_t'(1));
    bus.cmd_x0    = X_W'(x0);
    bus.cmd_x1    = X_W'(x1);
    bus.cmd_y0    = ADDR_W'(y0);
    bus.cmd_y1    = ADDR_W'(y1);
    bus.cmd_color = c;
`ifdef VRAM_FILL_XOR_EN
    bus.cmd_xor   = xr;
`endif
    bus.cmd_valid = 1'b1;
    x1c = (x1 > ROW_W - 1) ? ROW_W - 1 : x1;
    y1c = (y1 > ROWS - 1) ? ROWS - 1 : y1;
    if (x0 <= x1c && y0 <= y1c) begin
      for (int y = y0; y <= y1c; y++) begin
        for (int i = 0; i < ROW_W; i++) m[i] = (i >= x0) && (i <= x1c);
        e.addr = y;
        e.data = xr ? (ref_mem[y] ^ m) : ((ref_mem[y] & ~m) | (c ? m : '0));
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Wait for done (bounded), check latency, pulse width and scoreboard drain.
  task automatic wait_done(input string tag, input int limit);
    int lat;
    lat = 1;
    while (bus.done !== 1'b1 && lat < limit + 16) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, row_t'(bus.done), row_t'(1));
    check({tag, "_latency_ok"}, row_t'(lat <= limit), row_t'(1));
    @(negedge clk);
    check({tag, "_done_single"}, row_t'(bus.done), row_t'(0));
    check({tag, "_queue_drained"}, row_t'(exp_q.size()), row_t'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   w0;
    int   d0;
    int   wa0;
    int   k;
    int   bad_rows;
    row_t e2;
    row_t e3;

    for (int r = 0; r < ROWS; r++) begin
      mem[r]     = '0;
      ref_mem[r] = '0;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = 1'b0;
`ifdef VRAM_FILL_XOR_EN
    bus.cmd_xor   = 1'b0;
`endif

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", row_t'(bus.cmd_ready), row_t'(0));
    check("rst_busy", row_t'(bus.busy), row_t'(0));
    check("rst_done", row_t'(bus.done), row_t'(0));
    check("rst_write_active", row_t'(bus.write_active), row_t'(0));
    check("rst_vram_addr", row_t'(bus.vram_addr), row_t'(0));
    check("rst_write_vram", bus.write_vram, row_t'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", row_t'(bus.cmd_ready), row_t'(1));

    // 1: full-width fill of rows 10..12
    w0 = writes;
    d0 = done_cnt;
    issue_cmd(0, 639, 10, 12, 1'b1, 1'b0);
    check("t1_busy", row_t'(bus.busy), row_t'(1));
    check("t1_ready_low", row_t'(bus.cmd_ready), row_t'(0));
    wait_done("t1", 16 * 3 + 9);
    check("t1_writes", row_t'(writes - w0), row_t'(3));
    check("t1_dones", row_t'(done_cnt - d0), row_t'(1));
    check("t1_row10", mem[10], '1);
    check("t1_row12", mem[12], '1);
    check("t1_row9", mem[9], '0);
    check("t1_row13", mem[13], '0);

    // 4: empty command (x0 > x1)
    w0  = writes;
    wa0 = wa_cnt;
    issue_cmd(20, 10, 30, 30, 1'b1, 1'b0);
    wait_done("t4", 2);
    check("t4_writes", row_t'(writes - w0), row_t'(0));
    check("t4_write_active", row_t'(wa_cnt - wa0), row_t'(0));

    // 3: clamped rectangle at the bottom-right corner
    w0 = writes;
    issue_cmd(600, 1000, 470, 511, 1'b1, 1'b0);
    wait_done("t3", 16 * 10 + 9);
    check("t3_writes", row_t'(writes - w0), row_t'(10));
    check("t3_bad_addr", row_t'(bad_addr), row_t'(0));
    e3 = '0;
    e3[639:600] = '1;
    check("t3_row479", mem[479], e3);
    check("t3_row470", mem[470], e3);
    check("t3_row469", mem[469], '0);

    // 5: reset while waiting to write row 2 of a 5-row fill
    w0 = writes;
    d0 = done_cnt;
    issue_cmd(0, 639, 100, 104, 1'b1, 1'b0);
    k = 0;
    while (!(bus.write_active === 1'b1 && bus.vram_addr == ADDR_W'(101) && bus.grant === 1'b0)
           && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_row2_write", row_t'(k < 200), row_t'(1));
    rst = 1'b1;
    @(negedge clk);
    check("t5_wa_after_rst", row_t'(bus.write_active), row_t'(0));
    check("t5_busy_after_rst", row_t'(bus.busy), row_t'(0));
    check("t5_ready_in_rst", row_t'(bus.cmd_ready), row_t'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after_rst", row_t'(bus.cmd_ready), row_t'(1));
    check("t5_writes", row_t'(writes - w0), row_t'(1));
    check("t5_no_done", row_t'(done_cnt - d0), row_t'(0));
    exp_q.delete();
    check("t5_row100", mem[100], '1);
    check("t5_row101", mem[101], '0);

    // 2: clear a byte span inside an all-ones row
    mem[5]     = '1;
    ref_mem[5] = '1;
    issue_cmd(8, 15, 5, 5, 1'b0, 1'b0);
    wait_done("t2", 16 + 9);
    e2 = '1;
    e2[15:8] = 8'h00;
    check("t2_row5", mem[5], e2);

`ifdef VRAM_FILL_XOR_EN
    // 6: XOR fill twice restores the original pattern
    mem[0]     = row_t'(8'hF0);
    ref_mem[0] = row_t'(8'hF0);
    issue_cmd(0, 7, 0, 0, 1'b0, 1'b1);
    wait_done("t6a", 16 + 9);
    check("t6a_row0", mem[0], row_t'(8'h0F));
    issue_cmd(0, 7, 0, 0, 1'b0, 1'b1);
    wait_done("t6b", 16 + 9);
    check("t6b_row0", mem[0], row_t'(8'hF0));
`endif

    // Whole-memory comparison against the model
    bad_rows = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (mem[r] !== ref_mem[r]) bad_rows++;
    end
    check("mem_matches_model", row_t'(bad_rows), row_t'(0));
    check("no_bad_addr", row_t'(bad_addr), row_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
